// File: rtl/countdown_ctrl.sv
// Sequencing controller for a 4-digit BCD countdown timer: preset edit, load/decrement pulses, expiry alarm.
// Latency: btn_start -> load one cycle later -> RUN the cycle after; outputs decode registered state/divider.
// Backpressure: none; button pulses are single-cycle events, consumed or ignored in the cycle they arrive.
module countdown_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       btn_digit,
  input  logic       btn_inc,
  input  logic [3:0] cnt_s1000,
  input  logic [3:0] cnt_s100,
  input  logic [3:0] cnt_s10,
  input  logic [3:0] cnt_s1,
  output logic [3:0] preset_1000,
  output logic [3:0] preset_100,
  output logic [3:0] preset_10,
  output logic [3:0] preset_1,
  output logic       load,
  output logic       decrease,
  output logic [1:0] digit_sel,
  output logic [2:0] state,
  output logic       running,
  output logic       alarm
);

  localparam int DW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [3:0][3:0] preset_q, preset_d;   // [0]=ones .. [3]=thousands
  logic [1:0]      digit_sel_q, digit_sel_d;
  logic [DW-1:0]   div_q, div_d;
  logic [AW-1:0]   alm_q, alm_d;

  logic zero;
  logic preset_zero;
  logic div_wrap;
  logic alm_last;

  assign zero        = (cnt_s1000 == 4'd0) && (cnt_s100 == 4'd0) &&
                       (cnt_s10 == 4'd0) && (cnt_s1 == 4'd0);
  assign preset_zero = (preset_q == '0);
  assign div_wrap    = (div_q == DW'(TICK_DIV - 1));
  assign alm_last    = (alm_q == AW'(ALARM_TICKS - 1));

  // Next-state, preset editing, tick divider and alarm tick counting.
  always_comb begin
    state_d     = state_q;
    preset_d    = preset_q;
    digit_sel_d = digit_sel_q;
    div_d       = div_q;
    alm_d       = alm_q;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        // Increment uses the old selection even when btn_digit arrives in the same cycle.
        if (btn_inc) begin
          if (preset_q[digit_sel_q] == 4'd9) preset_d[digit_sel_q] = 4'd0;
          else                               preset_d[digit_sel_q] = preset_q[digit_sel_q] + 4'd1;
        end
        if (btn_digit) digit_sel_d = digit_sel_q + 2'd1;
        // Clear and pause outrank start but have nothing to do while idle.
        if (btn_start && !btn_clear && !btn_pause && !preset_zero) state_d = S_LOAD;
      end
      S_LOAD: begin
        div_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (btn_clear) begin
          state_d = S_IDLE;
          div_d   = '0;
        end else if (zero) begin
          state_d = S_DONE;
          div_d   = '0;
        end else if (btn_pause) begin
          // The divider still advances on this edge: this cycle was a RUN cycle.
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (btn_clear) begin
          state_d = S_IDLE;
          div_d   = '0;
        end else if (btn_pause || btn_start) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (div_wrap) begin
          if (alm_last) begin
            state_d = S_IDLE;
            alm_d   = '0;
          end else begin
            alm_d = alm_q + 1'b1;
          end
        end
        if (btn_clear) begin
          state_d = S_IDLE;
          alm_d   = '0;
          div_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        div_d   = '0;
        alm_d   = '0;
      end
    endcase
  end

  // Register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      preset_q    <= '0;
      digit_sel_q <= 2'd0;
      div_q       <= '0;
      alm_q       <= '0;
    end else begin
      state_q     <= state_d;
      preset_q    <= preset_d;
      digit_sel_q <= digit_sel_d;
      div_q       <= div_d;
      alm_q       <= alm_d;
    end
  end

  // Outputs depend only on registered state, divider and the live counter value.
  assign load        = (state_q == S_LOAD);
  assign decrease    = (state_q == S_RUN) && div_wrap && !zero;
  assign running     = (state_q == S_RUN);
  assign alarm       = (state_q == S_DONE);
  assign state       = state_q;
  assign digit_sel   = digit_sel_q;
  assign preset_1    = preset_q[0];
  assign preset_10   = preset_q[1];
  assign preset_100  = preset_q[2];
  assign preset_1000 = preset_q[3];

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with a behavioural BCD down-counter attached.
// Uses TICK_DIV=4, ALARM_TICKS=2; expected values are hand-derived constants.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_countdown_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0, btn_pause = 1'b0, btn_clear = 1'b0;
  logic       btn_digit = 1'b0, btn_inc = 1'b0;
  logic [3:0] preset_1000, preset_100, preset_10, preset_1;
  logic       load, decrease, running, alarm;
  logic [1:0] digit_sel;
  logic [2:0] state;
  logic [15:0] cnt_q = 16'h0000;
  logic [15:0] preset;

  int checks   = 0;
  int failures = 0;

  countdown_ctrl #(.TICK_DIV(4), .ALARM_TICKS(2)) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn_start), .btn_pause(btn_pause), .btn_clear(btn_clear),
    .btn_digit(btn_digit), .btn_inc(btn_inc),
    .cnt_s1000(cnt_q[15:12]), .cnt_s100(cnt_q[11:8]), .cnt_s10(cnt_q[7:4]), .cnt_s1(cnt_q[3:0]),
    .preset_1000(preset_1000), .preset_100(preset_100), .preset_10(preset_10), .preset_1(preset_1),
    .load(load), .decrease(decrease), .digit_sel(digit_sel), .state(state),
    .running(running), .alarm(alarm)
  );

  assign preset = {preset_1000, preset_100, preset_10, preset_1};

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    bit done;
    r = v;
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!done) begin
        if (r[i*4 +: 4] != 4'd0) begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          done = 1'b1;
        end else begin
          r[i*4 +: 4] = 4'd9;
        end
      end
    end
    return r;
  endfunction

  // Behavioural down-counter chain fed by the controller.
  always @(posedge clk) begin
    if (load)          cnt_q <= preset;
    else if (decrease) cnt_q <= bcd_dec(cnt_q);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1; cyc(); btn_inc = 1'b0;
    end
  endtask

  task automatic press_digit(input int n);
    for (int i = 0; i < n; i++) begin
      btn_digit = 1'b1; cyc(); btn_digit = 1'b0;
    end
  endtask

  initial begin
    int k, ndec, bad, last_dec, alarm_rise, n, pdec, pbad;

    // ---------------- reset state ----------------
    cyc();
    do_reset();
    check("rst_state", state, 0);
    check("rst_preset", preset, 16'h0000);
    check("rst_digit_sel", digit_sel, 0);
    check("rst_load", load, 0);
    check("rst_decrease", decrease, 0);
    check("rst_running", running, 0);
    check("rst_alarm", alarm, 0);

    // ---------------- edit then run ----------------
    press_inc(3);
    check("edit_ones", preset, 16'h0003);
    press_digit(1);
    check("edit_digit_sel", digit_sel, 1);
    press_inc(2);
    check("edit_preset", preset, 16'h0023);
    btn_start = 1'b1; cyc(); btn_start = 1'b0;
    check("load_state", state, 1);
    check("load_pulse", load, 1);
    cyc();
    check("run_state", state, 2);
    check("run_running", running, 1);
    check("run_load_low", load, 0);
    check("run_cnt_preset", cnt_q, 16'h0023);
    k = 0; ndec = 0; bad = 0; last_dec = -100; alarm_rise = -1;
    while (k < 200 && alarm_rise < 0) begin
      if (decrease) begin
        ndec++;
        if (k % 4 != 3) bad++;
        last_dec = k;
      end
      if (alarm) alarm_rise = k;
      else begin
        cyc();
        k++;
      end
    end
    check("run_decrease_count", ndec, 23);
    check("run_decrease_phase_errors", bad, 0);
    check("run_first_cycle_of_last_dec", last_dec, 91);
    check("alarm_delay_after_last_dec", alarm_rise - last_dec, 2);
    check("done_state", state, 4);
    n = 0;
    while (alarm && n < 50) begin
      n++;
      cyc();
    end
    check("alarm_duration", n, 8);
    check("post_alarm_state", state, 0);
    check("post_alarm_preset", preset, 16'h0023);

    // ---------------- wrap rules ----------------
    do_reset();
    press_inc(9);
    check("wrap_ones_9", preset_1, 9);
    press_inc(1);
    check("wrap_ones_0", preset_1, 0);
    check("wrap_no_carry", preset_10, 0);
    press_digit(4);
    check("wrap_digit_sel", digit_sel, 0);
    press_digit(1);
    btn_inc = 1'b1; btn_digit = 1'b1; cyc(); btn_inc = 1'b0; btn_digit = 1'b0;
    check("inc_digit_same_cycle_preset", preset, 16'h0010);
    check("inc_digit_same_cycle_sel", digit_sel, 2);

    // ---------------- zero preset ----------------
    do_reset();
    btn_start = 1'b1; cyc(); btn_start = 1'b0;
    check("zero_start_state", state, 0);
    check("zero_start_load", load, 0);
    cyc();
    check("zero_start_state_later", state, 0);

    // ---------------- pause phase ----------------
    do_reset();
    press_inc(5);
    btn_start = 1'b1; cyc(); btn_start = 1'b0;
    cyc();                       // RUN, divider 0
    cyc(); cyc(); cyc();         // divider 3
    check("pause_first_dec", decrease, 1);
    cyc(); cyc();                // divider 1: two cycles into the tick
    check("pause_pre_no_dec", decrease, 0);
    btn_pause = 1'b1; cyc(); btn_pause = 1'b0;
    check("pause_state", state, 3);
    pdec = 0; pbad = 0;
    for (int j = 0; j < 10; j++) begin
      if (decrease) pdec++;
      if (state != 3'd3) pbad++;
      if (j == 9) btn_start = 1'b1;
      cyc();
    end
    btn_start = 1'b0;
    check("pause_no_dec", pdec, 0);
    check("pause_held", pbad, 0);
    check("resume_state", state, 2);
    check("resume_cycle1_no_dec", decrease, 0);
    cyc();
    check("resume_cycle2_dec", decrease, 1);

    // ---------------- priority and clear ----------------
    btn_inc = 1'b1; cyc(); btn_inc = 1'b0;
    check("run_inc_ignored", preset, 16'h0005);
    check("run_inc_state", state, 2);
    btn_clear = 1'b1; btn_pause = 1'b1; cyc(); btn_clear = 1'b0; btn_pause = 1'b0;
    check("clear_over_pause", state, 0);
    btn_start = 1'b1; cyc(); btn_start = 1'b0;
    n = 0;
    while (!alarm && n < 100) begin
      cyc();
      n++;
    end
    check("reach_done", alarm, 1);
    cyc();
    check("done_cycle2_alarm", alarm, 1);
    btn_clear = 1'b1; cyc(); btn_clear = 1'b0;
    check("done_clear_alarm", alarm, 0);
    check("done_clear_state", state, 0);
    check("done_clear_preset_kept", preset, 16'h0005);

    // ---------------- reset mid-run ----------------
    btn_start = 1'b1; cyc(); btn_start = 1'b0;
    cyc(); cyc(); cyc();
    check("midrun_state", state, 2);
    rst = 1'b1; cyc(); rst = 1'b0;
    check("midrun_rst_state", state, 0);
    check("midrun_rst_preset", preset, 16'h0000);
    check("midrun_rst_outputs", {load, decrease, running, alarm}, 4'b0000);
    check("midrun_rst_digit_sel", digit_sel, 0);
    btn_start = 1'b1; cyc(); btn_start = 1'b0;
    check("midrun_rst_start_ignored", state, 0);
    check("midrun_rst_no_load", load, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for the 4-digit BCD down-counter timer.
- Holds the user-edited preset and drives it onto the counter's initial-value inputs.
- Issues the one-cycle load pulse and the once-per-tick decrement pulse.
- Handles start/pause/clear buttons, detects expiry from the live counter value and raises a timed alarm.
- Sits between the debounced button logic and the down-counter chain; the display path reads the counter directly.

## Interface
Parameters:
- TICK_DIV, 50_000_000, clk cycles per count tick (1 Hz at 50 MHz); minimum 2
- ALARM_TICKS, 5, ticks the alarm stays asserted in DONE; minimum 1

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- btn_start  in  1  one-cycle pulse, debounced upstream
- btn_pause  in  1  one-cycle pulse
- btn_clear  in  1  one-cycle pulse
- btn_digit  in  1  one-cycle pulse, advance edit digit
- btn_inc  in  1  one-cycle pulse, increment edited digit
- cnt_s1000, cnt_s100, cnt_s10, cnt_s1  in  4 each  live BCD counter value
- preset_1000, preset_100, preset_10, preset_1  out  4 each  BCD preset to counter initial-value inputs
- load  out  1  counter load strobe; counter takes preset on the edge where load=1
- decrease  out  1  counter decrement enable, one cycle per tick
- digit_sel  out  2  edited digit: 0=ones, 1=tens, 2=hundreds, 3=thousands
- state  out  3  IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4
- running  out  1  high in RUN
- alarm  out  1  high in DONE

## Operation
- Reset: state IDLE, presets 0000, digit_sel 0, divider 0, alarm tick count 0; load, decrease, running, alarm all 0.
- zero = all four cnt digits equal 0. preset_zero = all four presets equal 0.
- Button priority in every state: clear > pause > start. btn_digit and btn_inc are ignored outside IDLE.
- IDLE:
  - btn_inc adds 1 to the selected preset digit; 9 wraps to 0 with no carry.
  - btn_digit advances digit_sel 0→1→2→3→0.
  - If btn_inc and btn_digit arrive together, the increment applies to the old digit, then the selection advances.
  - btn_start with preset nonzero → LOAD. With preset_zero, btn_start is ignored.
- LOAD:
  - load=1 for exactly this cycle; the divider is cleared.
  - Next state is RUN unconditionally; buttons are ignored in LOAD.
- RUN:
  - The divider counts 0..TICK_DIV-1 and wraps.
  - decrease=1 in the cycle where divider==TICK_DIV-1 and zero=0.
  - zero=1 → DONE; decrease is suppressed in that cycle.
  - btn_clear → IDLE. btn_pause → PAUSE.
  - Buttons take effect at the edge; a decrease coinciding with a pause or clear still fires.
  - clear together with zero → IDLE.
- PAUSE:
  - The divider holds its value and decrease=0.
  - btn_start or btn_pause → RUN; the divider resumes from the held value.
  - btn_clear → IDLE.
- DONE:
  - alarm=1. The divider is cleared on entry, then free-runs.
  - Each wrap increments the alarm tick count; after ALARM_TICKS wraps → IDLE and the count is cleared.
  - btn_clear → IDLE immediately. Start and pause are ignored.
- Presets are retained across runs; only rst clears them. Returning to IDLE does not clear them.
- Outputs load, decrease, running and alarm are decoded from registered state and divider only; no button input reaches an output combinationally.

## Timing
- btn_start sampled at edge T (IDLE) → LOAD during cycle T+1 (load=1) → RUN from T+2.
- The counter shows the preset from T+2.
- First decrease is in cycle T+2+TICK_DIV-1; subsequent decreases come every TICK_DIV cycles.
- The counter reaches 0000 at the edge of the final decrease. Zero is seen the next cycle, and DONE follows one edge later, so the alarm rises 2 cycles after the last decrease cycle.
- Alarm duration is ALARM_TICKS×TICK_DIV cycles, measured from DONE entry; then IDLE.
- Pause/resume preserves the phase: total RUN cycles between consecutive decreases is always TICK_DIV.
- rst mid-operation returns every register to its reset value on the next edge, whatever the state.

## Test plan
Use TICK_DIV=4 and ALARM_TICKS=2, with a behavioural down-counter model attached.
- Edit then run: rst; btn_inc×3; btn_digit; btn_inc×2; btn_start → preset 0023, load in the cycle after start, decrease every 4 cycles, 23 decreases, alarm high 8 cycles, then IDLE with preset still 0023.
- Wrap rules: btn_inc×10 on digit 0 → preset_1 returns to 0; btn_digit×4 → digit_sel 0; btn_inc with btn_digit on digit_sel=1 → preset_10 increments, digit_sel=2.
- Zero preset: btn_start with 0000 → state stays IDLE, load never asserts.
- Pause phase: pause 2 cycles into a tick, hold 10 cycles, then resume with btn_start → next decrease exactly 2 RUN cycles after resume, no decrease during PAUSE.
- Priority and clear: btn_clear with btn_pause in RUN → IDLE. btn_clear 1 cycle into DONE → alarm drops the next cycle. btn_inc during RUN → preset unchanged.
- Reset mid-run: assert rst in RUN → next cycle state=0, presets 0000, outputs 0; btn_start afterwards is ignored.
